ppg_analyzer: RTL and testbench

PPG_ANALYZER -- requirements
Module: ppg_analyzer

---
 rtl/ppg_pkg.sv | 12 +
 rtl/ppg_channel_stats.sv | 33 +++
 rtl/ppg_analyzer.sv | 163 ++++++++++++++++
 tb/tb_ppg_analyzer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG analyzer: ADC width, default window/hysteresis, FSM states.
package ppg_pkg;
  localparam int ADC_W      = 8;
  localparam int WINDOW_DEF = 16;
  localparam int HYST_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    PUBLISH = 2'd2
  } state_t;
endpackage

// File: rtl/ppg_channel_stats.sv
// Per-channel running min/max over one window, with AC (span) and DC (midpoint) derived from them.
module ppg_channel_stats
  import ppg_pkg::*;
(
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             vld,
  input  logic [ADC_W-1:0] sample,
  output logic [ADC_W-1:0] ac,
  output logic [ADC_W-1:0] dc
);
  logic [ADC_W-1:0] mn, mx;
  logic [ADC_W:0]   sum;

  // A sample landing on the clear cycle seeds the next window instead of being lost.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mn <= '1;
      mx <= '0;
    end else if (clear) begin
      mn <= vld ? sample : '1;
      mx <= vld ? sample : '0;
    end else if (vld) begin
      if (sample < mn) mn <= sample;
      if (sample > mx) mx <= sample;
    end
  end

  assign sum = {1'b0, mx} + {1'b0, mn};
  assign ac  = (mx >= mn) ? mx - mn : '0;
  assign dc  = sum[ADC_W:1];
endmodule

// File: rtl/ppg_analyzer.sv
// PPG window analyzer: captures RED/IR samples on LED falling edges, publishes per-window
// amplitude/midpoint and IR beat count through a valid/ready result register.
module ppg_analyzer
  import ppg_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int HYST   = HYST_DEF
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             Setting_Done,
  input  logic             LED_RED,
  input  logic             LED_IR,
  input  logic [ADC_W-1:0] RED_ADC_Value,
  input  logic [ADC_W-1:0] IR_ADC_Value,
  output logic             Result_Valid,
  input  logic             Result_Ready,
  output logic [ADC_W-1:0] RED_AC,
  output logic [ADC_W-1:0] RED_DC,
  output logic [ADC_W-1:0] IR_AC,
  output logic [ADC_W-1:0] IR_DC,
  output logic [ADC_W-1:0] Beat_Count,
  output logic             Overrun
);
  localparam int PW = $clog2(WINDOW);

  logic [1:0]       rst_sync;
  logic             srst_n;
  state_t           state, nxt;
  logic             led_red_q, led_ir_q, red_vld, ir_vld;
  logic [ADC_W-1:0] red_smp, ir_smp;
  logic             acq, pub, red_ok, ir_ok, last;
  logic [PW-1:0]    pair_cnt;
  logic             red_seen, armed, first_win;
  logic [ADC_W-1:0] beat_cnt, prev_dc, thr_lo, thr_hi;
  logic [ADC_W:0]   lo_w, hi_w;
  logic [ADC_W-1:0] red_ac, red_dc, ir_ac, ir_dc;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign srst_n = rst_sync[1];

  assign acq    = (state == ACQUIRE);
  assign pub    = (state == PUBLISH);
  assign red_ok = red_vld & (state != IDLE);
  assign ir_ok  = ir_vld & red_seen & acq;
  assign last   = ir_ok & (pair_cnt == PW'(WINDOW - 1));

  always_ff @(posedge CLK or negedge srst_n) begin
    if (!srst_n) begin
      led_red_q <= 1'b0;
      led_ir_q  <= 1'b0;
      red_vld   <= 1'b0;
      ir_vld    <= 1'b0;
      red_smp   <= '0;
      ir_smp    <= '0;
    end else begin
      led_red_q <= LED_RED;
      led_ir_q  <= LED_IR;
      red_vld   <= acq & led_red_q & ~LED_RED;
      ir_vld    <= acq & led_ir_q & ~LED_IR;
      if (led_red_q & ~LED_RED) red_smp <= RED_ADC_Value;
      if (led_ir_q & ~LED_IR)   ir_smp  <= IR_ADC_Value;
    end
  end

  ppg_channel_stats u_red (
    .CLK(CLK), .rst_n(srst_n), .clear(~acq), .vld(red_ok), .sample(red_smp),
    .ac(red_ac), .dc(red_dc)
  );
  ppg_channel_stats u_ir (
    .CLK(CLK), .rst_n(srst_n), .clear(~acq), .vld(ir_ok), .sample(ir_smp),
    .ac(ir_ac), .dc(ir_dc)
  );

  always_ff @(posedge CLK or negedge srst_n) begin
    if (!srst_n) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (Setting_Done) nxt = ACQUIRE;
      ACQUIRE: if (last) nxt = PUBLISH;
      PUBLISH: nxt = ACQUIRE;
      default: nxt = IDLE;
    endcase
    if (!Setting_Done) nxt = IDLE;
  end

  // Thresholds around the previous window's IR midpoint, clamped to the ADC range.
  assign hi_w   = {1'b0, prev_dc} + (ADC_W+1)'(HYST);
  assign lo_w   = {1'b0, prev_dc} - (ADC_W+1)'(HYST);
  assign thr_hi = hi_w[ADC_W] ? '1 : hi_w[ADC_W-1:0];
  assign thr_lo = lo_w[ADC_W] ? '0 : lo_w[ADC_W-1:0];

  always_ff @(posedge CLK or negedge srst_n) begin
    if (!srst_n) begin
      pair_cnt  <= '0;
      red_seen  <= 1'b0;
      armed     <= 1'b0;
      beat_cnt  <= '0;
      first_win <= 1'b1;
      prev_dc   <= '0;
    end else begin
      case (state)
        ACQUIRE: begin
          if (red_ok) red_seen <= 1'b1;
          if (ir_ok)  pair_cnt <= pair_cnt + PW'(1);
          if (ir_ok && !first_win) begin
            if (ir_smp < thr_lo) armed <= 1'b1;
            else if (armed && ir_smp > thr_hi) begin
              armed <= 1'b0;
              if (beat_cnt != '1) beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        PUBLISH: begin
          pair_cnt  <= '0;
          red_seen  <= red_ok;
          beat_cnt  <= '0;
          first_win <= 1'b0;
          prev_dc   <= ir_dc;
        end
        default: begin
          pair_cnt  <= '0;
          red_seen  <= 1'b0;
          armed     <= 1'b0;
          beat_cnt  <= '0;
          first_win <= 1'b1;
        end
      endcase
    end
  end

  // A publish that coincides with acceptance keeps Valid high with fresh data and no overrun.
  always_ff @(posedge CLK or negedge srst_n) begin
    if (!srst_n) begin
      Result_Valid <= 1'b0;
      Overrun      <= 1'b0;
      RED_AC       <= '0;
      RED_DC       <= '0;
      IR_AC        <= '0;
      IR_DC        <= '0;
      Beat_Count   <= '0;
    end else if (pub) begin
      Result_Valid <= 1'b1;
      Overrun      <= Result_Valid & ~Result_Ready;
      RED_AC       <= red_ac;
      RED_DC       <= red_dc;
      IR_AC        <= ir_ac;
      IR_DC        <= ir_dc;
      Beat_Count   <= beat_cnt;
    end else if (Result_Valid && Result_Ready) begin
      Result_Valid <= 1'b0;
      Overrun      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ppg_analyzer.sv
// Self-checking bench for ppg_analyzer (WINDOW=4, HYST=8): table of windows plus hand sequences.
module tb_ppg_analyzer;
  logic       CLK = 1'b0;
  logic       rst_n, Setting_Done, LED_RED, LED_IR, Result_Ready;
  logic [7:0] RED_ADC_Value, IR_ADC_Value;
  logic       Result_Valid, Overrun;
  logic [7:0] RED_AC, RED_DC, IR_AC, IR_DC, Beat_Count;

  always #5 CLK = ~CLK;

  ppg_analyzer #(.WINDOW(4), .HYST(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .Setting_Done(Setting_Done),
    .LED_RED(LED_RED), .LED_IR(LED_IR),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .Result_Valid(Result_Valid), .Result_Ready(Result_Ready),
    .RED_AC(RED_AC), .RED_DC(RED_DC), .IR_AC(IR_AC), .IR_DC(IR_DC),
    .Beat_Count(Beat_Count), .Overrun(Overrun)
  );

  typedef struct {
    logic [31:0] red, ir;
    int rac, rdc, iac, idc, beat, ovr;
    bit acc;
  } win_t;
  typedef struct { int rac, rdc, iac, idc, beat, ovr; } exp_t;

  exp_t sb[$];
  win_t tbl[5];
  win_t s1, s2;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    n_cmp++;
    if (^act === 1'bx || int'(act) != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = 8'(a); b8 = 8'(b); c8 = 8'(c); d8 = 8'(d);
    return {d8, c8, b8, a8};
  endfunction

  task automatic send_red(input logic [7:0] r);
    RED_ADC_Value = r;
    LED_RED = 1'b1;
    tick(); tick();
    LED_RED = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic pair(input logic [7:0] r, input logic [7:0] i);
    send_red(r);
    IR_ADC_Value = i;
    LED_IR = 1'b1;
    tick(); tick();
    LED_IR = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {7'd0, Result_Valid}, 1);
      chk({tag, "_red_ac"}, RED_AC, e.rac);
      chk({tag, "_red_dc"}, RED_DC, e.rdc);
      chk({tag, "_ir_ac"}, IR_AC, e.iac);
      chk({tag, "_ir_dc"}, IR_DC, e.idc);
      chk({tag, "_beat"}, Beat_Count, e.beat);
      chk({tag, "_ovr"}, {7'd0, Overrun}, e.ovr);
    end
  endtask

  // Last IR fall is sampled one edge after the drive; result must appear two edges after that.
  task automatic run_window(input string tag, input win_t w, input bit lat);
    exp_t e;
    for (int j = 0; j < 3; j++) pair(w.red[8*j +: 8], w.ir[8*j +: 8]);
    send_red(w.red[31:24]);
    IR_ADC_Value = w.ir[31:24];
    LED_IR = 1'b1;
    tick(); tick();
    e = '{w.rac, w.rdc, w.iac, w.idc, w.beat, w.ovr};
    sb.push_back(e);
    LED_IR = 1'b0;
    tick(); tick();
    if (lat) chk({tag, "_early"}, {7'd0, Result_Valid}, 0);
    tick();
    check_out(tag);
    if (w.acc) begin
      Result_Ready = 1'b1;
      tick();
      Result_Ready = 1'b0;
      chk({tag, "_acc_valid"}, {7'd0, Result_Valid}, 0);
      chk({tag, "_acc_ovr"}, {7'd0, Overrun}, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; Setting_Done = 1'b0; LED_RED = 1'b0; LED_IR = 1'b0;
    Result_Ready = 1'b0; RED_ADC_Value = '0; IR_ADC_Value = '0;

    //           red                       ir                         rac rdc iac idc bt ov acc
    tbl[0] = '{p4(100,140,120,110), p4(50,90,70,60),     40, 120, 40,  70, 0, 0, 1'b1};
    tbl[1] = '{p4(10,20,30,40),     p4(60,80,60,80),     30,  25, 20,  70, 2, 0, 1'b0};
    tbl[2] = '{p4(255,0,255,0),     p4(0,255,0,255),    255, 127, 255, 127, 2, 1, 1'b1};
    tbl[3] = '{p4(200,200,200,200), p4(200,200,200,200),  0, 200,  0, 200, 0, 0, 1'b1};
    tbl[4] = '{p4(5,5,5,5),         p4(250,100,250,100),  0,   5, 150, 175, 1, 0, 1'b0};
    s1     = '{p4(50,60,50,60),     p4(150,160,150,160), 10,  55, 10, 155, 0, 1, 1'b0};
    s2     = '{p4(100,140,120,110), p4(60,80,60,80),     40, 120, 20,  70, 0, 0, 1'b1};

    tick(); tick(); tick();
    chk("rst_valid", {7'd0, Result_Valid}, 0);
    chk("rst_ovr", {7'd0, Overrun}, 0);
    chk("rst_red_ac", RED_AC, 0);
    chk("rst_red_dc", RED_DC, 0);
    chk("rst_ir_ac", IR_AC, 0);
    chk("rst_ir_dc", IR_DC, 0);
    chk("rst_beat", Beat_Count, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    Setting_Done = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_window($sformatf("win%0d", i), tbl[i], i == 0);

    // Partial window abandoned by dropping Setting_Done; held result must survive.
    pair(1, 3);
    pair(2, 4);
    Setting_Done = 1'b0;
    tick(); tick(); tick();
    chk("sd_drop_valid", {7'd0, Result_Valid}, 1);
    chk("sd_drop_ir_ac", IR_AC, 150);
    chk("sd_drop_ir_dc", IR_DC, 175);
    chk("sd_drop_ovr", {7'd0, Overrun}, 0);
    Setting_Done = 1'b1;
    tick();
    run_window("sd_restart", s1, 1'b0);

    // Reset in the middle of a window while a result is pending.
    pair(7, 9);
    pair(8, 9);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {7'd0, Result_Valid}, 0);
    chk("rst_mid_ovr", {7'd0, Overrun}, 0);
    chk("rst_mid_red_ac", RED_AC, 0);
    chk("rst_mid_red_dc", RED_DC, 0);
    chk("rst_mid_ir_dc", IR_DC, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    run_window("post_rst", s2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
